// File: rtl/rgb_pwm_fader_if.sv
// Configuration port for rgb_pwm_fader.
// A master presents one channel update (chan/duty/mode) with cfg_valid.
// The slave takes it on a cycle where cfg_valid && cfg_ready are both high.
//   cfg_valid  master->slave  update request
//   cfg_ready  slave->master  update slot free
//   cfg_chan   master->slave  target channel, CH_W bits
//   cfg_duty   master->slave  duty 0..2^PWM_W-1
//   cfg_mode   master->slave  00 static, 01 blink, 10 breathe, 11 off
interface rgb_pwm_fader_if #(
  parameter int NUM_CH = 3,
  parameter int PWM_W  = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_chan;
  logic [PWM_W-1:0] cfg_duty;
  logic [1:0]       cfg_mode;

  modport master (output cfg_valid, cfg_chan, cfg_duty, cfg_mode, input cfg_ready);
  modport slave  (input cfg_valid, cfg_chan, cfg_duty, cfg_mode, output cfg_ready);
endinterface

// File: rtl/rgb_pwm_fader.sv
// NUM_CH-channel PWM generator with static/blink/breathe/off modes per channel.
// pwm_out[i] drives the RGB LED driver PWM inputs (default R/G/B).
// Updates arrive over the cfg interface, are parked in a single pending slot,
// and are committed only on the tick where pwm_cnt wraps, so a period is never
// cut short or stretched by a write.
//   hw_clk        system clock
//   rst_n         async active-low reset
//   cfg           configuration port (slave side)
//   pwm_out       registered PWM outputs, one per channel
//   period_start  one-cycle pulse in the cycle after pwm_cnt wraps to 0
module rgb_pwm_fader #(
  parameter int NUM_CH          = 3,
  parameter int PWM_W           = 8,
  parameter int PRESCALE        = 1,
  parameter int BLINK_PERIODS   = 64,
  parameter int BREATHE_PERIODS = 2
) (
  input  logic              hw_clk,
  input  logic              rst_n,
  rgb_pwm_fader_if.slave    cfg,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_start
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BL_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam int BR_W = (BREATHE_PERIODS > 1) ? $clog2(BREATHE_PERIODS) : 1;

  localparam logic [PS_W-1:0]  PRESC_LAST   = PS_W'(PRESCALE - 1);
  localparam logic [PWM_W-1:0] DUTY_MAX     = '1;
  localparam logic [PWM_W-1:0] CNT_LAST     = DUTY_MAX - PWM_W'(1);
  localparam logic [BL_W-1:0]  BLINK_LAST   = BL_W'(BLINK_PERIODS - 1);
  localparam logic [BR_W-1:0]  BREATHE_LAST = BR_W'(BREATHE_PERIODS - 1);

  typedef enum logic [1:0] {
    MODE_STATIC  = 2'b00,
    MODE_BLINK   = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_OFF     = 2'b11
  } mode_t;

  typedef enum logic {SLOT_FREE, SLOT_PENDING} slot_t;
  typedef enum logic {ENV_UP, ENV_DOWN} env_dir_t;

  slot_t            slot_q, slot_d;
  logic             accept, commit;
  logic [PS_W-1:0]  presc_cnt;
  logic [PWM_W-1:0] pwm_cnt;
  logic             tick, wrap_tick;

  logic [CH_W-1:0]  pend_chan;
  logic [PWM_W-1:0] pend_duty;
  mode_t            pend_mode;

  logic [PWM_W-1:0] duty [NUM_CH];
  mode_t            mode [NUM_CH];

  logic [BL_W-1:0]  blink_cnt;
  logic             blink_on;
  logic [BR_W-1:0]  breathe_cnt;
  logic [PWM_W-1:0] env;
  env_dir_t         env_dir;
  logic [PWM_W:0]   env_p1;

  logic [PWM_W-1:0]  eff_duty [NUM_CH];
  logic [NUM_CH-1:0] pwm_d;

  assign tick          = (presc_cnt == PRESC_LAST);
  assign wrap_tick     = tick && (pwm_cnt == CNT_LAST);
  assign cfg.cfg_ready = (slot_q == SLOT_FREE);
  assign env_p1        = {1'b0, env} + (PWM_W+1)'(1);

  // Accept needs a free slot and commit needs a pending one, so an update
  // accepted on a wrap tick can only commit on the following wrap.
  always_comb begin
    slot_d = slot_q;
    accept = 1'b0;
    commit = 1'b0;
    case (slot_q)
      SLOT_FREE: begin
        if (cfg.cfg_valid) begin
          accept = 1'b1;
          slot_d = SLOT_PENDING;
        end
      end
      SLOT_PENDING: begin
        if (wrap_tick) begin
          commit = 1'b1;
          slot_d = SLOT_FREE;
        end
      end
      default: slot_d = SLOT_FREE;
    endcase
  end

  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q       <= SLOT_FREE;
      presc_cnt    <= '0;
      pwm_cnt      <= '0;
      period_start <= 1'b0;
      pwm_out      <= '0;
      pend_chan    <= '0;
      pend_duty    <= '0;
      pend_mode    <= MODE_STATIC;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        duty[i] <= '0;
        mode[i] <= MODE_STATIC;
      end
    end else begin
      slot_q       <= slot_d;
      period_start <= wrap_tick;
      pwm_out      <= pwm_d;
      presc_cnt    <= tick ? '0 : presc_cnt + PS_W'(1);
      if (tick) pwm_cnt <= (pwm_cnt == CNT_LAST) ? '0 : pwm_cnt + PWM_W'(1);
      if (accept) begin
        pend_chan <= cfg.cfg_chan;
        pend_duty <= cfg.cfg_duty;
        pend_mode <= mode_t'(cfg.cfg_mode);
      end
      // Out-of-range channel numbers match no index and are dropped here.
      if (commit) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (pend_chan == CH_W'(i)) begin
            duty[i] <= pend_duty;
            mode[i] <= pend_mode;
          end
        end
      end
    end
  end

  // Blink phase and breathe envelope are shared by all channels and advance
  // only on wrap ticks.
  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_on    <= 1'b1;
      breathe_cnt <= '0;
      env         <= '0;
      env_dir     <= ENV_UP;
    end else if (wrap_tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BL_W'(1);
      end
      if (breathe_cnt == BREATHE_LAST) begin
        breathe_cnt <= '0;
        if (env_dir == ENV_UP) begin
          env <= env + PWM_W'(1);
          if (env == CNT_LAST) env_dir <= ENV_DOWN;
        end else begin
          env <= env - PWM_W'(1);
          if (env == PWM_W'(1)) env_dir <= ENV_UP;
        end
      end else begin
        breathe_cnt <= breathe_cnt + BR_W'(1);
      end
    end
  end

  // Breathe scales duty by (env+1)/2^PWM_W; the full-width product cannot
  // overflow and the shifted result always fits PWM_W bits.
  always_comb begin
    pwm_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      eff_duty[i] = '0;
      case (mode[i])
        MODE_STATIC:  eff_duty[i] = duty[i];
        MODE_BLINK:   eff_duty[i] = blink_on ? duty[i] : '0;
        MODE_BREATHE: eff_duty[i] = PWM_W'(({{(PWM_W+1){1'b0}}, duty[i]} *
                                            {{PWM_W{1'b0}}, env_p1}) >> PWM_W);
        default:      eff_duty[i] = '0;
      endcase
      pwm_d[i] = (pwm_cnt < eff_duty[i]);
    end
  end
endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Directed bench for rgb_pwm_fader.
// u0: 3 ch, PWM_W=8, PRESCALE=1, BLINK_PERIODS=2, BREATHE_PERIODS=1
// u1: 3 ch, PWM_W=8, PRESCALE=3
// u2: 1 ch, PWM_W=3, BREATHE_PERIODS=1 (short period, envelope turnarounds)
module tb_rgb_pwm_fader;
  logic hw_clk = 1'b0;
  logic rst_n;
  always #5 hw_clk = ~hw_clk;

  rgb_pwm_fader_if #(.NUM_CH(3), .PWM_W(8)) if0 ();
  rgb_pwm_fader_if #(.NUM_CH(3), .PWM_W(8)) if1 ();
  rgb_pwm_fader_if #(.NUM_CH(1), .PWM_W(3)) if2 ();

  logic [2:0] pwm0, pwm1;
  logic [0:0] pwm2;
  logic       ps0, ps1, ps2;

  rgb_pwm_fader #(.NUM_CH(3), .PWM_W(8), .PRESCALE(1), .BLINK_PERIODS(2), .BREATHE_PERIODS(1))
    u0 (.hw_clk(hw_clk), .rst_n(rst_n), .cfg(if0), .pwm_out(pwm0), .period_start(ps0));
  rgb_pwm_fader #(.NUM_CH(3), .PWM_W(8), .PRESCALE(3), .BLINK_PERIODS(64), .BREATHE_PERIODS(2))
    u1 (.hw_clk(hw_clk), .rst_n(rst_n), .cfg(if1), .pwm_out(pwm1), .period_start(ps1));
  rgb_pwm_fader #(.NUM_CH(1), .PWM_W(3), .PRESCALE(1), .BLINK_PERIODS(1), .BREATHE_PERIODS(1))
    u2 (.hw_clk(hw_clk), .rst_n(rst_n), .cfg(if2), .pwm_out(pwm2), .period_start(ps2));

  int checks = 0;
  int errors = 0;

  // Wrap pulses seen since reset; at a negedge showing period_start=1 the
  // period just begun has index wraps+1 (period 0 is the one out of reset).
  int wraps0, wraps2;
  always @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      wraps0 <= 0;
      wraps2 <= 0;
    end else begin
      wraps0 <= wraps0 + int'(ps0);
      wraps2 <= wraps2 + int'(ps2);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready0(input string tag);
    int n = 0;
    while (if0.cfg_ready !== 1'b1 && n < 1000) begin
      @(negedge hw_clk);
      n++;
    end
    check({tag, " ready"}, 32'(if0.cfg_ready), 1);
  endtask

  task automatic write0(input string tag, input logic [1:0] c, input logic [7:0] d,
                        input logic [1:0] m);
    wait_ready0(tag);
    if0.cfg_valid = 1'b1;
    if0.cfg_chan  = c;
    if0.cfg_duty  = d;
    if0.cfg_mode  = m;
    @(negedge hw_clk);
    if0.cfg_valid = 1'b0;
    check({tag, " ready low"}, 32'(if0.cfg_ready), 0);
  endtask

  // Commit frees the slot on the wrap tick, so ready returns with period_start.
  task automatic commit0(input string tag);
    wait_ready0(tag);
    check({tag, " commit on wrap"}, 32'(ps0), 1);
  endtask

  task automatic wait_ps0(input string tag);
    int n = 0;
    @(negedge hw_clk);
    while (ps0 !== 1'b1 && n < 1000) begin
      @(negedge hw_clk);
      n++;
    end
    check({tag, " period_start"}, 32'(ps0), 1);
  endtask

  // Call at a negedge showing period_start=1; counts the next full period.
  task automatic measure0(input string tag, output int h0, output int h1, output int h2);
    int early = 0;
    h0 = 0; h1 = 0; h2 = 0;
    for (int j = 1; j <= 255; j++) begin
      @(negedge hw_clk);
      h0 += int'(pwm0[0]);
      h1 += int'(pwm0[1]);
      h2 += int'(pwm0[2]);
      if (j < 255 && ps0 === 1'b1) early++;
    end
    check({tag, " early period_start"}, early, 0);
    check({tag, " period_start at 255"}, 32'(ps0), 1);
  endtask

  initial begin
    int h0, h1, h2, p, env, hi, early, n;
    rst_n = 1'b0;
    if0.cfg_valid = 1'b0; if0.cfg_chan = '0; if0.cfg_duty = '0; if0.cfg_mode = '0;
    if1.cfg_valid = 1'b0; if1.cfg_chan = '0; if1.cfg_duty = '0; if1.cfg_mode = '0;
    if2.cfg_valid = 1'b0; if2.cfg_chan = '0; if2.cfg_duty = '0; if2.cfg_mode = '0;
    repeat (3) @(negedge hw_clk);
    check("reset pwm0", 32'(pwm0), 0);
    check("reset ps0", 32'(ps0), 0);
    check("reset ready0", 32'(if0.cfg_ready), 1);
    check("reset pwm2", 32'(pwm2), 0);
    rst_n = 1'b1;

    // T1: static 64 on ch0
    write0("t1 wr", 2'd0, 8'd64, 2'b00);
    commit0("t1");
    for (int k = 0; k < 2; k++) begin
      measure0("t1", h0, h1, h2);
      check("t1 ch0 high", h0, 64);
      check("t1 ch1 high", h1, 0);
    end

    // T2: duty 255 and duty 0 static hold steady
    write0("t2 wr1", 2'd1, 8'd255, 2'b00);
    commit0("t2a");
    write0("t2 wr2", 2'd2, 8'd0, 2'b00);
    commit0("t2b");
    for (int k = 0; k < 3; k++) begin
      measure0("t2", h0, h1, h2);
      check("t2 ch0 high", h0, 64);
      check("t2 ch1 high", h1, 255);
      check("t2 ch2 high", h2, 0);
    end

    // T3: mid-period update 10 -> 200; write while busy is ignored
    write0("t3 wr", 2'd0, 8'd10, 2'b00);
    commit0("t3");
    h0 = 0;
    for (int j = 1; j <= 255; j++) begin
      @(negedge hw_clk);
      h0 += int'(pwm0[0]);
      if (j == 100) begin
        if0.cfg_valid = 1'b1; if0.cfg_chan = 2'd0; if0.cfg_duty = 8'd200; if0.cfg_mode = 2'b00;
      end
      if (j == 101) begin
        if0.cfg_valid = 1'b0;
        check("t3 ready low after accept", 32'(if0.cfg_ready), 0);
      end
      if (j == 150) begin
        if0.cfg_valid = 1'b1; if0.cfg_chan = 2'd0; if0.cfg_duty = 8'd0; if0.cfg_mode = 2'b11;
      end
      if (j == 151) if0.cfg_valid = 1'b0;
      if (j == 254) check("t3 ready low until commit", 32'(if0.cfg_ready), 0);
    end
    check("t3 old period ch0 high", h0, 10);
    check("t3 wrap", 32'(ps0), 1);
    check("t3 ready at commit", 32'(if0.cfg_ready), 1);
    measure0("t3 next", h0, h1, h2);
    check("t3 new period ch0 high", h0, 200);

    // T4: blink on ch1, BLINK_PERIODS=2
    write0("t4 wr", 2'd1, 8'd255, 2'b01);
    commit0("t4");
    for (int k = 0; k < 4; k++) begin
      p = wraps0 + 1;
      measure0("t4", h0, h1, h2);
      check("t4 ch1 blink high", h1, (((p / 2) % 2) == 0) ? 255 : 0);
    end

    // T5: breathe on ch2, BREATHE_PERIODS=1
    write0("t5 wr", 2'd2, 8'd255, 2'b10);
    commit0("t5");
    for (int k = 0; k < 3; k++) begin
      p = wraps0 + 1;
      env = (p <= 255) ? p : 510 - p;
      measure0("t5", h0, h1, h2);
      check("t5 ch2 breathe high", h2, (255 * (env + 1)) >> 8);
    end

    // T6: reset with a pending write
    write0("t6 wr", 2'd0, 8'd128, 2'b00);
    repeat (50) @(negedge hw_clk);
    check("t6 ch0 high before reset", 32'(pwm0[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6 pwm0 async reset", 32'(pwm0), 0);
    check("t6 ps0 async reset", 32'(ps0), 0);
    check("t6 ready async reset", 32'(if0.cfg_ready), 1);
    @(negedge hw_clk);
    rst_n = 1'b1;
    wait_ps0("t6 first");
    measure0("t6 lost", h0, h1, h2);
    check("t6 pending lost ch0", h0, 0);
    check("t6 ch1 reset", h1, 0);
    check("t6 ch2 reset", h2, 0);

    // Accept on the wrap-tick cycle commits one period later
    for (int j = 1; j <= 255; j++) begin
      @(negedge hw_clk);
      if (j == 254) begin
        if0.cfg_valid = 1'b1; if0.cfg_chan = 2'd0; if0.cfg_duty = 8'd50; if0.cfg_mode = 2'b00;
      end
    end
    if0.cfg_valid = 1'b0;
    check("t6 wrap accept ps", 32'(ps0), 1);
    check("t6 wrap accept ready low", 32'(if0.cfg_ready), 0);
    measure0("t6 hold", h0, h1, h2);
    check("t6 not committed same wrap", h0, 0);
    check("t6 ready after one period", 32'(if0.cfg_ready), 1);
    measure0("t6 new", h0, h1, h2);
    check("t6 committed next wrap", h0, 50);

    // u1: PRESCALE=3 -> 765-cycle period, duty 2 -> 6 high cycles
    if1.cfg_valid = 1'b1; if1.cfg_chan = 2'd0; if1.cfg_duty = 8'd2; if1.cfg_mode = 2'b00;
    @(negedge hw_clk);
    if1.cfg_valid = 1'b0;
    n = 0;
    while (if1.cfg_ready !== 1'b1 && n < 2000) begin
      @(negedge hw_clk);
      n++;
    end
    check("u1 commit ready", 32'(if1.cfg_ready), 1);
    check("u1 commit on wrap", 32'(ps1), 1);
    hi = 0; early = 0;
    for (int j = 1; j <= 765; j++) begin
      @(negedge hw_clk);
      hi += int'(pwm1[0]);
      if (j < 765 && ps1 === 1'b1) early++;
    end
    check("u1 early period_start", early, 0);
    check("u1 period_start at 765", 32'(ps1), 1);
    check("u1 ch0 high", hi, 6);

    // u2: out-of-range channel is a no-op, then envelope turnarounds
    if2.cfg_valid = 1'b1; if2.cfg_chan = 1'b1; if2.cfg_duty = 3'd7; if2.cfg_mode = 2'b00;
    @(negedge hw_clk);
    if2.cfg_valid = 1'b0;
    check("u2 ready low", 32'(if2.cfg_ready), 0);
    n = 0;
    while (if2.cfg_ready !== 1'b1 && n < 100) begin
      @(negedge hw_clk);
      n++;
    end
    check("u2 commit on wrap", 32'(ps2), 1);
    hi = 0;
    for (int j = 1; j <= 7; j++) begin
      @(negedge hw_clk);
      hi += int'(pwm2[0]);
    end
    check("u2 bad chan no-op", hi, 0);
    if2.cfg_valid = 1'b1; if2.cfg_chan = 1'b0; if2.cfg_duty = 3'd7; if2.cfg_mode = 2'b10;
    @(negedge hw_clk);
    if2.cfg_valid = 1'b0;
    n = 0;
    while (if2.cfg_ready !== 1'b1 && n < 100) begin
      @(negedge hw_clk);
      n++;
    end
    check("u2 breathe commit", 32'(ps2), 1);
    for (int k = 0; k < 20; k++) begin
      p = (wraps2 + 1) % 14;
      env = (p <= 7) ? p : 14 - p;
      hi = 0;
      for (int j = 1; j <= 7; j++) begin
        @(negedge hw_clk);
        hi += int'(pwm2[0]);
      end
      check("u2 breathe high", hi, (7 * (env + 1)) >> 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
